// File: rtl/instr_mem_loader.sv
// Instruction memory with a 1-cycle registered fetch port and a streaming
// valid/ready load port; fetches are stalled while a program load is running.
module instr_mem_loader #(
  parameter int                ADDR_W   = 5,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  output logic              fetch_err,
  output logic              fetch_stall,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  logic [ADDR_W:0]   ptr;
  logic [ADDR_W:0]   len_q;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic wr_en;
  logic last_wr;
  logic fetch_go;
  logic addr_ok;

  assign load_busy   = (state == LOAD);
  assign load_ready  = (state == LOAD);
  assign fetch_stall = fetch_en & load_busy;
  assign fetch_go    = fetch_en & ~load_busy;
  assign wr_en       = load_ready & load_valid;
  assign last_wr     = wr_en && (ptr == len_q - ONE_L);
  // Widen by one bit so DEPTH == 2**ADDR_W still compares correctly.
  assign addr_ok     = ({1'b0, fetch_addr} < DEPTH_L);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      len_q       <= '0;
      fetch_valid <= 1'b0;
      fetch_err   <= 1'b0;
      fetch_data  <= '0;
      load_done   <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_done   <= 1'b0;
      load_err    <= 1'b0;
      fetch_valid <= fetch_go;
      fetch_err   <= fetch_go & ~addr_ok;
      if (fetch_go)
        fetch_data <= addr_ok ? mem[fetch_addr[IDX_W-1:0]] : NOP_WORD;

      case (state)
        IDLE: begin
          if (load_start) begin
            if (load_len == '0) begin
              load_done <= 1'b1;
            end else if (load_len > DEPTH_L) begin
              load_err <= 1'b1;
            end else begin
              len_q <= load_len;
              ptr   <= '0;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (wr_en) begin
            ptr <= ptr + ONE_L;
            if (last_wr) begin
              state     <= IDLE;
              load_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is not reset; reset only blocks the write so an abort is immediate.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en)
      mem[ptr[IDX_W-1:0]] <= load_data;
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: load streaming, fetch, stall, length
// boundaries and reset mid-load, with hand-computed expected values.
module tb_instr_mem_loader;
  localparam int          ADDR_W = 5;
  localparam int          DATA_W = 32;
  localparam int          DEPTH  = 20;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid, fetch_err, fetch_stall;
  logic              load_start;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready, load_busy, load_done, load_err;

  int vecs = 0;
  int errs = 0;

  instr_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .fetch_valid(fetch_valid), .fetch_err(fetch_err), .fetch_stall(fetch_stall),
    .load_start(load_start), .load_len(load_len), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 0; fetch_addr = '0; load_start = 0; load_len = '0;
    load_valid = 0; load_data = '0;
    tick(); tick();
    vecs++;
    if ({fetch_valid, fetch_err, load_done, load_err, load_busy, load_ready} !== 6'b0) begin
      errs++;
      $display("FAIL reset_flags: got v%b e%b d%b le%b b%b r%b want all 0",
               fetch_valid, fetch_err, load_done, load_err, load_busy, load_ready);
    end
    vecs++;
    if (fetch_data !== '0) begin errs++; $display("FAIL reset_data: got %h want 0", fetch_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_stream();
    logic        vpat [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] dpat [5] = '{32'h11, 32'h22, 32'hdead, 32'h33, 32'h44};
    int rdy_cnt = 0;
    load_start = 1; load_len = 6'd4;
    tick();
    load_start = 0;
    for (int k = 0; k < 5; k++) begin
      load_valid = vpat[k]; load_data = dpat[k];
      #1;
      if (load_ready === 1'b1) rdy_cnt++;
      vecs++;
      if (load_done !== 1'b0 || load_busy !== 1'b1) begin
        errs++; $display("FAIL stream_cyc%0d: got done=%b busy=%b want done=0 busy=1", k, load_done, load_busy);
      end
      tick();
    end
    load_valid = 0;
    vecs++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || load_ready !== 1'b0) begin
      errs++; $display("FAIL stream_done: got done=%b busy=%b rdy=%b want 1 0 0", load_done, load_busy, load_ready);
    end
    vecs++;
    if (rdy_cnt != 5) begin errs++; $display("FAIL stream_rdy_cycles: got %0d want 5", rdy_cnt); end
    tick();
    vecs++;
    if (load_done !== 1'b0) begin errs++; $display("FAIL stream_done_pulse: got %b want 0", load_done); end
  endtask

  task automatic test_fetch_b2b();
    logic [31:0] exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      fetch_en = 1; fetch_addr = ADDR_W'(i);
      tick();
      vecs++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== exp[i]) begin
        errs++; $display("FAIL b2b_addr%0d: got v=%b e=%b d=%h want 1 0 %h", i, fetch_valid, fetch_err, fetch_data, exp[i]);
      end
    end
    fetch_en = 0;
    tick();
    vecs++;
    if (fetch_valid !== 1'b0 || fetch_data !== 32'h44) begin
      errs++; $display("FAIL idle_hold: got v=%b d=%h want 0 00000044", fetch_valid, fetch_data);
    end
  endtask

  task automatic test_out_of_range();
    logic [ADDR_W-1:0] addrs [2] = '{5'd25, 5'd20};
    for (int i = 0; i < 2; i++) begin
      fetch_en = 1; fetch_addr = addrs[i];
      tick();
      vecs++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b1 || fetch_data !== NOP) begin
        errs++; $display("FAIL oor_addr%0d: got v=%b e=%b d=%h want 1 1 %h", addrs[i], fetch_valid, fetch_err, fetch_data, NOP);
      end
    end
    fetch_en = 0;
    tick();
  endtask

  task automatic test_stall();
    load_start = 1; load_len = 6'd8;
    tick();
    load_start = 0;
    fetch_en = 1; fetch_addr = '0;
    for (int k = 0; k < 8; k++) begin
      load_valid = 1; load_data = 32'hA0 + 32'(k);
      #1;
      vecs++;
      if (fetch_stall !== 1'b1) begin errs++; $display("FAIL stall_cyc%0d: got %b want 1", k, fetch_stall); end
      tick();
      if (k < 7) begin
        vecs++;
        if (fetch_valid !== 1'b0) begin errs++; $display("FAIL stall_drop%0d: got valid=%b want 0", k, fetch_valid); end
      end
    end
    load_valid = 0;
    vecs++;
    if (load_done !== 1'b1 || fetch_stall !== 1'b0) begin
      errs++; $display("FAIL stall_release: got done=%b stall=%b want 1 0", load_done, fetch_stall);
    end
    tick();
    vecs++;
    if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== 32'hA0) begin
      errs++; $display("FAIL stall_retry: got v=%b e=%b d=%h want 1 0 000000a0", fetch_valid, fetch_err, fetch_data);
    end
    fetch_en = 0;
    tick();
  endtask

  task automatic test_len_bounds();
    // length 0: immediate done, no busy, no writes
    load_start = 1; load_len = 6'd0;
    tick();
    load_start = 0;
    vecs++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || load_err !== 1'b0) begin
      errs++; $display("FAIL len0: got done=%b busy=%b err=%b want 1 0 0", load_done, load_busy, load_err);
    end
    tick();
    vecs++;
    if (load_done !== 1'b0) begin errs++; $display("FAIL len0_pulse: got %b want 0", load_done); end
    // length DEPTH+1: error, memory untouched
    load_start = 1; load_len = 6'(DEPTH + 1); load_valid = 1; load_data = 32'hBAD;
    tick();
    load_start = 0;
    vecs++;
    if (load_err !== 1'b1 || load_done !== 1'b0 || load_busy !== 1'b0) begin
      errs++; $display("FAIL len_over: got err=%b done=%b busy=%b want 1 0 0", load_err, load_done, load_busy);
    end
    fetch_en = 1; fetch_addr = '0;
    tick();
    load_valid = 0;
    vecs++;
    if (load_err !== 1'b0 || fetch_data !== 32'hA0) begin
      errs++; $display("FAIL len_over_mem: got err=%b d=%h want 0 000000a0", load_err, fetch_data);
    end
    fetch_en = 0;
    // length DEPTH: whole array written
    load_start = 1; load_len = 6'(DEPTH);
    tick();
    load_start = 0;
    for (int k = 0; k < DEPTH; k++) begin
      load_valid = 1; load_data = 32'h100 + 32'(k);
      tick();
    end
    load_valid = 0;
    vecs++;
    if (load_done !== 1'b1 || load_busy !== 1'b0) begin
      errs++; $display("FAIL lenmax_done: got done=%b busy=%b want 1 0", load_done, load_busy);
    end
    for (int k = 0; k < DEPTH; k++) begin
      fetch_en = 1; fetch_addr = ADDR_W'(k);
      tick();
      vecs++;
      if (fetch_valid !== 1'b1 || fetch_err !== 1'b0 || fetch_data !== 32'h100 + 32'(k)) begin
        errs++; $display("FAIL lenmax_rd%0d: got v=%b e=%b d=%h want 1 0 %h", k, fetch_valid, fetch_err, fetch_data, 32'h100 + 32'(k));
      end
    end
    fetch_en = 0;
    tick();
  endtask

  task automatic test_reset_midload();
    logic [31:0] exp [6] = '{32'h200, 32'h201, 32'h202, 32'h103, 32'h104, 32'h105};
    int done_seen = 0;
    load_start = 1; load_len = 6'd6;
    tick();
    load_start = 0;
    for (int k = 0; k < 3; k++) begin
      load_valid = 1; load_data = 32'h200 + 32'(k);
      tick();
    end
    // fourth word is presented while reset hits and must be dropped
    load_data = 32'h203; rst_n = 0;
    tick();
    vecs++;
    if ({load_busy, load_ready, load_done, load_err, fetch_valid, fetch_err} !== 6'b0 || fetch_data !== '0) begin
      errs++; $display("FAIL midrst_out: got b%b r%b d%b le%b v%b e%b data=%h want all 0",
                       load_busy, load_ready, load_done, load_err, fetch_valid, fetch_err, fetch_data);
    end
    rst_n = 1; load_valid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (load_done === 1'b1) done_seen++;
    end
    vecs++;
    if (done_seen != 0) begin errs++; $display("FAIL midrst_nodone: got %0d pulses want 0", done_seen); end
    for (int k = 0; k < 6; k++) begin
      fetch_en = 1; fetch_addr = ADDR_W'(k);
      tick();
      vecs++;
      if (fetch_valid !== 1'b1 || fetch_data !== exp[k]) begin
        errs++; $display("FAIL midrst_mem%0d: got v=%b d=%h want 1 %h", k, fetch_valid, fetch_data, exp[k]);
      end
    end
    fetch_en = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_stream();
    test_fetch_b2b();
    test_out_of_range();
    test_stall();
    test_len_bounds();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
